// File: rtl/mdu_defs.sv
// Shared MDU operation codes, imported by the E-stage controller and the MDU.
package mdu_defs;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] NOP   = 4'd0;
  localparam logic [OP_W-1:0] MULT  = 4'd1;
  localparam logic [OP_W-1:0] MULTU = 4'd2;
  localparam logic [OP_W-1:0] DIV   = 4'd3;
  localparam logic [OP_W-1:0] DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MTLO  = 4'd8;

endpackage

// File: rtl/mdu_latency_ctr.sv
// Loadable down-counter that models MDU latency; flags busy and the commit cycle.
module mdu_latency_ctr #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy,
  output logic          commit
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy   = (cnt != '0);
  assign commit = (cnt == CW'(1));

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: latched result, modelled latency, HI/LO move ops.
module e_mdu
  import mdu_defs::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_MDUA,
  input  logic [WIDTH-1:0] E_MDUB,
  input  logic [3:0]       E_MDUOp,
  input  logic             E_MDUValid,
  output logic [WIDTH-1:0] E_MDURe,
  output logic             E_FlagMDU,
  output logic             E_MDUStart,
  output logic             E_MDUBusy
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  logic             is_mul, is_div, is_signed;
  logic [W2-1:0]    ext_a, ext_b, prod;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b, div_b, q_mag, r_mag, quo, rem;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_we;
  logic [WIDTH-1:0] hi, lo, p_hi, p_lo;
  logic             p_we;
  logic             commit;
  logic [CW-1:0]    load_val;

  assign is_mul     = (E_MDUOp == MULT) || (E_MDUOp == MULTU);
  assign is_div     = (E_MDUOp == DIV)  || (E_MDUOp == DIVU);
  assign is_signed  = (E_MDUOp == MULT) || (E_MDUOp == DIV);
  assign E_MDUStart = E_MDUValid && (is_mul || is_div) && !E_MDUBusy;
  assign load_val   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  // Full result computed up front; divides by zero are accepted but never committed.
  always_comb begin
    neg_a  = is_signed && E_MDUA[WIDTH-1];
    neg_b  = is_signed && E_MDUB[WIDTH-1];
    ext_a  = {{WIDTH{neg_a}}, E_MDUA};
    ext_b  = {{WIDTH{neg_b}}, E_MDUB};
    prod   = ext_a * ext_b;
    abs_a  = neg_a ? (WIDTH'(0) - E_MDUA) : E_MDUA;
    abs_b  = neg_b ? (WIDTH'(0) - E_MDUB) : E_MDUB;
    div_b  = (abs_b == '0) ? WIDTH'(1) : abs_b;
    q_mag  = abs_a / div_b;
    r_mag  = abs_a % div_b;
    quo    = (neg_a ^ neg_b) ? (WIDTH'(0) - q_mag) : q_mag;
    rem    = neg_a ? (WIDTH'(0) - r_mag) : r_mag;
    res_hi = is_mul ? prod[W2-1:WIDTH] : rem;
    res_lo = is_mul ? prod[WIDTH-1:0]  : quo;
    res_we = is_mul || (E_MDUB != '0);
  end

  mdu_latency_ctr #(.CW(CW)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (E_MDUStart),
    .load_val (load_val),
    .busy     (E_MDUBusy),
    .commit   (commit)
  );

  // Commit happens only while busy and moves only while idle, so they never collide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      p_hi <= '0;
      p_lo <= '0;
      p_we <= 1'b0;
    end else begin
      if (E_MDUStart) begin
        p_hi <= res_hi;
        p_lo <= res_lo;
        p_we <= res_we;
      end
      if (commit && p_we) begin
        hi <= p_hi;
        lo <= p_lo;
      end
      if (E_MDUValid && !E_MDUBusy && (E_MDUOp == MTHI)) hi <= E_MDUA;
      if (E_MDUValid && !E_MDUBusy && (E_MDUOp == MTLO)) lo <= E_MDUA;
    end
  end

  always_comb begin
    E_MDURe = '0;
    if (E_MDUValid && (E_MDUOp == MFHI)) E_MDURe = hi;
    if (E_MDUValid && (E_MDUOp == MFLO)) E_MDURe = lo;
  end

  assign E_FlagMDU = ~^E_MDURe;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed and random ops against an arithmetic reference model.
module tb_e_mdu;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        valid;
  logic [31:0] re;
  logic        flag, start, busy;

  logic [7:0]  a8, b8;
  logic [3:0]  op8;
  logic        v8;
  logic [7:0]  re8;
  logic        f8, st8, bz8;

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [31:0] mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  e_mdu u_dut (
    .clk(clk), .reset(reset), .E_MDUA(a), .E_MDUB(b), .E_MDUOp(op),
    .E_MDUValid(valid), .E_MDURe(re), .E_FlagMDU(flag),
    .E_MDUStart(start), .E_MDUBusy(busy)
  );

  e_mdu #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut8 (
    .clk(clk), .reset(reset), .E_MDUA(a8), .E_MDUB(b8), .E_MDUOp(op8),
    .E_MDUValid(v8), .E_MDURe(re8), .E_FlagMDU(f8),
    .E_MDUStart(st8), .E_MDUBusy(bz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  function automatic void model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] h, output logic [31:0] l, output bit we);
    longint sq, sr;
    logic [63:0] p;
    h = '0; l = '0; we = 1'b1; p = '0; sq = 0; sr = 0;
    case (mop)
      MULT:  p = 64'(longint'($signed(ma)) * longint'($signed(mb)));
      MULTU: p = {32'h0, ma} * {32'h0, mb};
      DIV: if (mb == 0) we = 1'b0;
           else begin
             sq = longint'($signed(ma)) / longint'($signed(mb));
             sr = longint'($signed(ma)) % longint'($signed(mb));
             p  = {sr[31:0], sq[31:0]};
           end
      DIVU: if (mb == 0) we = 1'b0;
            else p = {ma % mb, ma / mb};
      default: we = 1'b0;
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  task automatic read_check(input string tag);
    op = MFHI; valid = 1'b1; #1;
    check({tag, " mfhi"}, 64'(re), 64'(mhi));
    check({tag, " flag_hi"}, 64'(flag), 64'($countones(mhi) % 2 == 0));
    op = MFLO; #1;
    check({tag, " mflo"}, 64'(re), 64'(mlo));
    check({tag, " flag_lo"}, 64'(flag), 64'($countones(mlo) % 2 == 0));
    valid = 1'b0; op = NOP;
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic exp_start);
    op = o; a = x; b = y; valid = 1'b1; #1;
    check({tag, " start"}, 64'(start), 64'(exp_start));
    cycle();
    valid = 1'b0; op = NOP;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    logic [31:0] h, l;
    bit we;
    lat = (o == MULT || o == MULTU) ? 5 : 10;
    do_op(tag, o, x, y, 1'b1);
    for (int i = 0; i < lat; i++) begin
      check({tag, " busy"}, 64'(busy), 64'(1));
      cycle();
    end
    check({tag, " idle"}, 64'(busy), 64'(0));
    model(o, x, y, h, l, we);
    if (we) begin
      mhi = h; mlo = l;
    end
    read_check(tag);
  endtask

  task automatic run_move(input string tag, input logic [3:0] o, input logic [31:0] x);
    do_op(tag, o, x, $urandom, 1'b0);
    if (o == MTHI) mhi = x; else mlo = x;
    read_check(tag);
  endtask

  initial begin
    logic [3:0] ops [6];
    logic [31:0] ra, rb;
    logic [3:0] ro;
    ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU; ops[4] = MTHI; ops[5] = MTLO;
    reset = 1'b0; a = '0; b = '0; op = NOP; valid = 1'b0;
    a8 = '0; b8 = '0; op8 = NOP; v8 = 1'b0;
    cycle(); cycle();
    check("rst busy", 64'(busy), 64'(0));
    check("rst start", 64'(start), 64'(0));
    check("rst re", 64'(re), 64'(0));
    check("rst flag", 64'(flag), 64'(1));
    reset = 1'b1;
    cycle();

    run_op("mult_m2x3", MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult hi const", 64'(mhi), 64'h0000_0000_FFFF_FFFF);
    check("mult lo const", 64'(mlo), 64'h0000_0000_FFFF_FFFA);

    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2);
    check("div lo const", 64'(mlo), 64'h0000_0000_FFFF_FFFD);
    check("div hi const", 64'(mhi), 64'h0000_0000_FFFF_FFFF);

    run_op("divu_by0", DIVU, 32'd7, 32'd0);
    check("div0 lo kept", 64'(mlo), 64'h0000_0000_FFFF_FFFD);

    run_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    run_move("mthi", MTHI, 32'h1234);
    op = MFHI; valid = 1'b1; #1;
    check("mthi flag", 64'(flag), 64'(0));
    valid = 1'b0; op = NOP;
    run_move("mtlo", MTLO, $urandom);

    // Start and move ops presented while busy must be dropped.
    ra = $urandom; rb = $urandom | 32'h1;
    do_op("ovl divu", DIVU, ra, rb, 1'b1);
    op = MULT; a = 32'd9; b = 32'd9; valid = 1'b1; #1;
    check("ovl mult start", 64'(start), 64'(0));
    check("ovl busy", 64'(busy), 64'(1));
    cycle();
    op = MTLO; a = 32'h55; #1;
    check("ovl mtlo start", 64'(start), 64'(0));
    cycle();
    valid = 1'b0; op = NOP;
    for (int i = 2; i < 10; i++) begin
      check("ovl busy tail", 64'(busy), 64'(1));
      cycle();
    end
    check("ovl idle", 64'(busy), 64'(0));
    mhi = ra % rb; mlo = ra / rb;
    read_check("ovl");

    for (int n = 0; n < 20; n++) begin
      ro = ops[$urandom_range(0, 5)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 9)));
      if (ro == MTHI || ro == MTLO) run_move("rnd move", ro, ra);
      else run_op("rnd op", ro, ra, rb);
    end

    do_op("rstmid", MULT, 32'd3, 32'd4, 1'b1);
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("rstmid busy", 64'(busy), 64'(0));
    mhi = '0; mlo = '0;
    for (int i = 0; i < 6; i++) cycle();
    check("rstmid still idle", 64'(busy), 64'(0));
    read_check("rstmid");

    op8 = MULTU; a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1; #1;
    check("w8 start", 64'(st8), 64'(1));
    cycle();
    v8 = 1'b0; op8 = NOP;
    check("w8 busy", 64'(bz8), 64'(1));
    cycle();
    check("w8 idle", 64'(bz8), 64'(0));
    op8 = MFHI; v8 = 1'b1; #1;
    check("w8 hi", 64'(re8), 64'hFE);
    op8 = MFLO; #1;
    check("w8 lo", 64'(re8), 64'h01);
    check("w8 flag", 64'(f8), 64'(0));
    v8 = 1'b0; op8 = NOP;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
